// File: rtl/bist_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bist_pkg
//  Description : Shared definitions for the BIST sender/receiver pair:
//                pattern-mode enum, LFSR tap constants, LFSR step function
//                and the LFSR-state-to-link-width expansion function.
//  Revision    : 1.0 - initial release
// ============================================================================
package bist_pkg;

    typedef enum logic [1:0] {
        MODE_LFSR    = 2'd0,
        MODE_WALK    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_ALT     = 2'd3
    } bist_mode_e;

    localparam int          c_LFSR_W       = 32;
    // Taps 32, 22, 2, 1 expressed as bit positions 31, 21, 1, 0.
    localparam logic [31:0] c_LFSR_TAPS    = 32'h8020_0003;
    // Upper bound on link width handled by expand_pattern.
    localparam int          c_MAX_CHANNELS = 1024;

    // Fibonacci step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [c_LFSR_W-1:0] lfsr_next(input logic [c_LFSR_W-1:0] state);
        return {state[c_LFSR_W-2:0], ^(state & c_LFSR_TAPS)};
    endfunction

    // Replicate the 32-bit state from bit 0 upward; bits at or above
    // `width` are zero so callers can simply truncate the result.
    function automatic logic [c_MAX_CHANNELS-1:0] expand_pattern(
        input logic [c_LFSR_W-1:0] state,
        input int                  width
    );
        logic [c_MAX_CHANNELS-1:0] v_out;
        v_out = '0;
        for (int i = 0; i < c_MAX_CHANNELS; i++) begin
            if (i < width) begin
                v_out[i] = state[5'(i)];
            end
        end
        return v_out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bist_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bist_pattern_gen
//  Description : Expected-pattern generator shared by BIST sender and
//                receiver. Holds the LFSR, case parity and walking index and
//                muxes them by pattern mode.
//  Ports       : clk, reset (async, active-high)
//                load     - restart at case 0 (LFSR <= SEED)
//                advance  - step to the next case
//                mode     - pattern mode
//                pattern  - expected word for the current case
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_pattern_gen
    import bist_pkg::*;
#(
    parameter int          TEST_CHANNELS = 70,
    parameter logic [31:0] SEED          = 32'hdeadbeef
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     advance,
    input  bist_mode_e               mode,
    output logic [TEST_CHANNELS-1:0] pattern
);

    localparam int c_WALK_W = (TEST_CHANNELS > 1) ? $clog2(TEST_CHANNELS) : 1;

    logic [31:0]             r_lfsr;
    logic                    r_odd;
    logic [c_WALK_W-1:0]     r_walk;

    logic [TEST_CHANNELS-1:0] w_lfsr;
    logic [TEST_CHANNELS-1:0] w_walk;
    logic [TEST_CHANNELS-1:0] w_checker;
    logic [TEST_CHANNELS-1:0] w_alt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
            r_odd  <= 1'b0;
            r_walk <= '0;
        end else if (load) begin
            r_lfsr <= SEED;
            r_odd  <= 1'b0;
            r_walk <= '0;
        end else if (advance) begin
            r_lfsr <= lfsr_next(r_lfsr);
            r_odd  <= ~r_odd;
            r_walk <= (r_walk == c_WALK_W'(TEST_CHANNELS - 1)) ? '0 : r_walk + c_WALK_W'(1);
        end
    end

    assign w_lfsr = TEST_CHANNELS'(expand_pattern(r_lfsr, TEST_CHANNELS));
    assign w_alt  = {TEST_CHANNELS{~r_odd}};

    always_comb begin
        w_walk         = '0;
        w_walk[r_walk] = 1'b1;
    end

    // Even cases put ones on odd channels; odd cases invert.
    for (genvar i = 0; i < TEST_CHANNELS; i++) begin : g_checker
        assign w_checker[i] = r_odd ^ ((i % 2) == 1);
    end

    always_comb begin
        pattern = w_lfsr;
        case (mode)
            MODE_LFSR:    pattern = w_lfsr;
            MODE_WALK:    pattern = w_walk;
            MODE_CHECKER: pattern = w_checker;
            MODE_ALT:     pattern = w_alt;
            default:      pattern = w_lfsr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bist_diag_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bist_diag_receiver
//  Description : Far-end BIST checker. Regenerates the expected pattern
//                stream, waits a programmable alignment latency, compares
//                TEST_CASES words and records per-channel stuck-high/low
//                flags plus a saturating count of failing cases.
//  Ports       : clk, reset (async, active-high)
//                start, mode, latency    - run control, sampled in IDLE
//                input_channels          - received link data
//                busy, done              - run status
//                failed, err_hi, err_lo  - diagnosis results
//                err_count               - failing-case count (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_diag_receiver
    import bist_pkg::*;
#(
    parameter int          TEST_CHANNELS = 70,
    parameter logic [31:0] SEED          = 32'hdeadbeef,
    parameter int          TEST_CASES    = 1000,
    parameter int          MAX_LATENCY   = 7,
    parameter int          ERR_CNT_W     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [1:0]                         mode,
    input  logic [$clog2(MAX_LATENCY+1)-1:0]   latency,
    input  logic [TEST_CHANNELS-1:0]           input_channels,
    output logic                               busy,
    output logic                               done,
    output logic                               failed,
    output logic [TEST_CHANNELS-1:0]           err_hi,
    output logic [TEST_CHANNELS-1:0]           err_lo,
    output logic [ERR_CNT_W-1:0]               err_count
);

    localparam int c_LAT_W  = $clog2(MAX_LATENCY + 1);
    localparam int c_CASE_W = $clog2(TEST_CASES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                   r_state;
    state_e                   w_next_state;
    logic [c_LAT_W-1:0]       r_align;
    logic [c_CASE_W-1:0]      r_case;
    bist_mode_e               r_mode;
    logic                     r_done;
    logic [TEST_CHANNELS-1:0] r_err_hi;
    logic [TEST_CHANNELS-1:0] r_err_lo;
    logic [ERR_CNT_W-1:0]     r_err_count;

    logic                     w_accept;
    logic                     w_compare;
    logic                     w_last;
    logic                     w_mismatch;
    logic [TEST_CHANNELS-1:0] w_expected;

    bist_pattern_gen #(
        .TEST_CHANNELS (TEST_CHANNELS),
        .SEED          (SEED)
    ) u_pattern_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (w_accept),
        .advance (w_compare),
        .mode    (r_mode),
        .pattern (w_expected)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_compare    = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = (latency == '0) ? ST_RUN : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (r_align == '0) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_compare = 1'b1;
                if (r_case == c_CASE_W'(TEST_CASES - 1)) begin
                    w_last       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_mismatch = (input_channels != w_expected);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_align     <= '0;
            r_case      <= '0;
            r_mode      <= MODE_LFSR;
            r_done      <= 1'b0;
            r_err_hi    <= '0;
            r_err_lo    <= '0;
            r_err_count <= '0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_mode      <= bist_mode_e'(mode);
                // ALIGN spans `latency` cycles, so count down from latency-1.
                r_align     <= latency - c_LAT_W'(1);
                r_case      <= '0;
                r_err_hi    <= '0;
                r_err_lo    <= '0;
                r_err_count <= '0;
            end
            if (r_state == ST_ALIGN && r_align != '0) begin
                r_align <= r_align - c_LAT_W'(1);
            end
            if (w_compare) begin
                r_case   <= r_case + c_CASE_W'(1);
                r_err_hi <= r_err_hi | (input_channels & ~w_expected);
                r_err_lo <= r_err_lo | (~input_channels & w_expected);
                if (w_mismatch && r_err_count != '1) begin
                    r_err_count <= r_err_count + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign failed    = |{r_err_hi, r_err_lo};
    assign err_hi    = r_err_hi;
    assign err_lo    = r_err_lo;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_bist_diag_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bist_diag_receiver
//  Description : Self-checking bench for bist_diag_receiver. A behavioural
//                model emits the sender stream, models link delay and faults,
//                and computes expected diagnosis results per run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_diag_receiver;

    localparam int          N     = 70;
    localparam int          CASES = 1000;
    localparam int          MAXL  = 7;
    localparam logic [31:0] SEEDV = 32'hdeadbeef;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [2:0]    latency;
    logic [N-1:0]  input_channels;

    logic          busy, done, failed;
    logic [N-1:0]  err_hi, err_lo;
    logic [15:0]   err_count;

    logic          s_busy, s_done, s_failed;
    logic [N-1:0]  s_err_hi, s_err_lo;
    logic [3:0]    s_err_count;

    bist_diag_receiver dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .latency(latency),
        .input_channels(input_channels), .busy(busy), .done(done), .failed(failed),
        .err_hi(err_hi), .err_lo(err_lo), .err_count(err_count)
    );

    bist_diag_receiver #(.ERR_CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .latency(latency),
        .input_channels(input_channels), .busy(s_busy), .done(s_done), .failed(s_failed),
        .err_hi(s_err_hi), .err_lo(s_err_lo), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] lfsr_tab [0:CASES+MAXL+8];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Expected word for case k, straight from the mode definitions.
    function automatic logic [N-1:0] pattern(input int md, input int k);
        logic [N-1:0] p;
        logic [31:0]  s;
        p = '0;
        s = lfsr_tab[k];
        for (int i = 0; i < N; i++) begin
            case (md)
                0:       p[i] = s[i % 32];
                1:       p[i] = (i == (k % N));
                2:       p[i] = ((i % 2) != (k % 2));
                default: p[i] = ((k % 2) == 0);
            endcase
        end
        return p;
    endfunction

    task automatic run(input string name, input int md, input int lat, input int dly,
                       input logic [N-1:0] stuck_hi, input logic [N-1:0] stuck_lo,
                       input int flip_pct, input bit poke_start, input int abort_at);
        logic [N-1:0] sent [$];
        logic [N-1:0] rx, e, m_hi, m_lo;
        int           m_cnt;
        bit           saw;
        m_hi = '0; m_lo = '0; m_cnt = 0;
        @(negedge clk);
        start = 1'b1; mode = 2'(md); latency = 3'(lat);
        @(posedge clk); #1;
        // Scramble sampled controls to prove they were latched.
        start = 1'b0; mode = 2'($urandom); latency = 3'($urandom);
        check({name, "_busy_start"}, busy, 1'b1);
        for (int c = 0; c < lat + CASES; c++) begin
            start = 1'b0;
            sent.push_back(pattern(md, c));
            rx = (c >= dly) ? sent[c - dly] : '0;
            rx = (rx | stuck_hi) & ~stuck_lo;
            if (flip_pct > 0 && $urandom_range(99, 0) < flip_pct)
                rx[$urandom_range(N - 1, 0)] ^= 1'b1;
            input_channels = rx;
            if (c >= lat) begin
                e = pattern(md, c - lat);
                m_hi |= rx & ~e;
                m_lo |= ~rx & e;
                if (rx != e) m_cnt++;
            end
            if (poke_start && c == lat + 300) start = 1'b1;
            if (c == lat + CASES - 1) check({name, "_done_early"}, done, 1'b0);
            if (abort_at >= 0 && c == lat + abort_at) begin
                reset = 1'b1;
                #1;
                check({name, "_rst_out"}, {busy, done, failed, err_hi, err_lo, err_count}, '0);
                check({name, "_rst_sat"}, {s_busy, s_done, s_failed, s_err_count}, '0);
                @(posedge clk); #1 reset = 1'b0;
                saw = 1'b0;
                repeat (CASES) begin
                    @(posedge clk); #1;
                    if (done) saw = 1'b1;
                end
                check({name, "_no_done"}, saw, 1'b0);
                check({name, "_idle"}, busy, 1'b0);
                return;
            end
            @(posedge clk); #1;
        end
        check({name, "_done"}, done, 1'b1);
        check({name, "_busy_end"}, busy, 1'b0);
        check({name, "_hi"}, err_hi, m_hi);
        check({name, "_lo"}, err_lo, m_lo);
        check({name, "_cnt"}, err_count, (m_cnt > 65535) ? 65535 : m_cnt);
        check({name, "_failed"}, failed, ((m_hi | m_lo) != '0));
        check({name, "_sat_cnt"}, s_err_count, (m_cnt > 15) ? 15 : m_cnt);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, done, 1'b0);
    endtask

    logic [N-1:0] one69, mask7, mask1;
    int           rl;

    initial begin
        logic [31:0] s;
        s = SEEDV;
        for (int k = 0; k <= CASES + MAXL + 8; k++) begin
            lfsr_tab[k] = s;
            s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
        end
        one69 = '0; one69[69] = 1'b1;
        mask7 = '0; mask7[7] = 1'b1;
        mask1 = '0; mask1[1] = 1'b1;

        reset = 1'b1; start = 1'b0; mode = '0; latency = '0; input_channels = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_main", {busy, done, failed, err_hi, err_lo, err_count}, '0);
        check("reset_sat", {s_busy, s_done, s_failed, s_err_count}, '0);
        @(negedge clk) reset = 1'b0;

        run("clean_m0", 0, 0, 0, '0, '0, 0, 0, -1);
        check("clean_m0_failed0", failed, 1'b0);

        run("stuck", 0, 0, 0, mask7, mask1, 0, 0, -1);
        check("stuck_hi_const", err_hi, 70'h80);
        check("stuck_lo_const", err_lo, 70'h2);

        run("dly3_l3", 0, 3, 3, '0, '0, 0, 0, -1);
        check("dly3_l3_ok", failed, 1'b0);
        run("dly3_l2", 0, 2, 3, '0, '0, 0, 0, -1);
        check("dly3_l2_bad", failed, 1'b1);
        run("dly3_l4", 0, 4, 3, '0, '0, 0, 0, -1);
        check("dly3_l4_bad", failed, 1'b1);

        run("walk69", 1, 0, 0, '0, one69, 0, 0, -1);
        check("walk69_lo", err_lo, one69);
        check("walk69_hi", err_hi, '0);
        check("walk69_cnt14", err_count, 14);

        run("alt_low", 3, 0, 0, '0, '1, 0, 0, -1);
        check("alt_low_sat15", s_err_count, 4'd15);
        check("alt_low_lo", s_err_lo, {N{1'b1}});
        check("alt_low_hi", s_err_hi, '0);

        run("poke", 2, 5, 5, '0, '0, 0, 1, -1);
        run("abort", 0, 0, 0, '0, '0, 0, 0, 500);

        for (int r = 0; r < 3; r++) begin
            rl = $urandom_range(MAXL, 0);
            run($sformatf("rand%0d", r), $urandom_range(3, 0), rl, rl,
                (($urandom_range(1, 0) == 1) ? mask7 : '0), '0, 1, 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
